ecg_haar_dwt2: RTL and testbench

Two-level Haar wavelet decomposition stage, directly downstream of the ECG sample source `ecg_clt_32bit`. It consumes the 32-bit signed ECG sample stream and emits level-1 and level-2 approximation/detail coefficients, each decimated by 2 per level. The QRS detector uses these coefficients for thresholding and peak search.

---
 rtl/ecg_haar_dwt2.sv | 87 ++++++++
 tb/tb_ecg_haar_dwt2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ecg_haar_dwt2.sv
// Two-level Haar DWT on the ECG sample stream. Each level pairs consecutive
// valid inputs into a floor-mean approximation and an (even - odd) detail.
module ecg_haar_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] x,
  output logic         out_valid,
  output logic [W-1:0] a,
  output logic [W:0]   d
);
  logic         p;
  logic [W-1:0] x_even;
  logic [W:0]   sum, dif;

  // One extra bit of headroom: the mean always fits back into W bits.
  assign sum = {x_even[W-1], x_even} + {x[W-1], x};
  assign dif = {x_even[W-1], x_even} - {x[W-1], x};

  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= 1'b0;
      x_even    <= '0;
      out_valid <= 1'b0;
      a         <= '0;
      d         <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        p <= ~p;
        if (!p) begin
          x_even <= x;
        end else begin
          a         <= sum[W:1];
          d         <= dif;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

module ecg_haar_dwt2 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_ecg,
  output logic          a1_valid,
  output logic [DW-1:0] a1,
  output logic [DW:0]   d1,
  output logic          a2_valid,
  output logic [DW-1:0] a2,
  output logic [DW:0]   d2
);
  localparam int LEVELS = 2;

  // Level g consumes lvl_a[g] and produces lvl_a[g+1]; index 0 is the raw stream.
  logic [LEVELS:0]           lvl_vld;
  logic [LEVELS:0][DW-1:0]   lvl_a;
  logic [LEVELS-1:0][DW:0]   lvl_d;

  assign lvl_vld[0] = in_valid;
  assign lvl_a[0]   = in_ecg;

  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    ecg_haar_stage #(.W(DW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (lvl_vld[g]),
      .x        (lvl_a[g]),
      .out_valid(lvl_vld[g+1]),
      .a        (lvl_a[g+1]),
      .d        (lvl_d[g])
    );
  end

  assign a1_valid = lvl_vld[1];
  assign a1       = lvl_a[1];
  assign d1       = lvl_d[0];
  assign a2_valid = lvl_vld[2];
  assign a2       = lvl_a[2];
  assign d2       = lvl_d[1];
endmodule

// File: tb/tb_ecg_haar_dwt2.sv
// Directed bench for ecg_haar_dwt2 with hand-computed coefficient values.
module tb_ecg_haar_dwt2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_ecg;
  logic          a1_valid, a2_valid;
  logic [DW-1:0] a1, a2;
  logic [DW:0]   d1, d2;

  int n_tests = 0;
  int n_fail  = 0;

  ecg_haar_dwt2 #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ecg  (in_ecg),
    .a1_valid(a1_valid),
    .a1      (a1),
    .d1      (d1),
    .a2_valid(a2_valid),
    .a2      (a2),
    .d2      (d2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle; outputs are observed 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] x);
    in_valid = v;
    in_ecg   = x;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a1_valid"}, longint'(a1_valid), 0);
    chk({tag, " a2_valid"}, longint'(a2_valid), 0);
    chk({tag, " a1"}, longint'($signed(a1)), 0);
    chk({tag, " d1"}, longint'($signed(d1)), 0);
    chk({tag, " a2"}, longint'($signed(a2)), 0);
    chk({tag, " d2"}, longint'($signed(d2)), 0);
  endtask

  task automatic chk_l1(input string tag, input longint ea, input longint ed);
    chk({tag, " a1_valid"}, longint'(a1_valid), 1);
    chk({tag, " a1"}, longint'($signed(a1)), ea);
    chk({tag, " d1"}, longint'($signed(d1)), ed);
  endtask

  task automatic chk_l2(input string tag, input longint ea, input longint ed);
    chk({tag, " a2_valid"}, longint'(a2_valid), 1);
    chk({tag, " a2"}, longint'($signed(a2)), ea);
    chk({tag, " d2"}, longint'($signed(d2)), ed);
  endtask

  initial begin
    logic [DW-1:0] smp [4];
    int n_a1, n_a2;
    smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 50;

    // Reset with a live input that must be ignored
    rst = 1'b1; in_valid = 1'b1; in_ecg = 32'h1234_5678;
    cyc(1'b1, 32'h1234_5678); chk_zero("rst0");
    cyc(1'b1, 32'h1234_5678); chk_zero("rst1");
    rst = 1'b0;
    cyc(1'b0, '0); chk_zero("rst_rel");

    // Continuous stream
    cyc(1'b1, smp[0]); chk("cont e1 a1_valid", longint'(a1_valid), 0);
    cyc(1'b1, smp[1]); chk_l1("cont e2", 15, -10);
    chk("cont e2 a2_valid", longint'(a2_valid), 0);
    cyc(1'b1, smp[2]); chk("cont e3 a1_valid", longint'(a1_valid), 0);
    chk("cont e3 a2_valid", longint'(a2_valid), 0);
    cyc(1'b1, smp[3]); chk_l1("cont e4", 40, -20);
    chk("cont e4 a2_valid", longint'(a2_valid), 0);
    cyc(1'b0, '0); chk_l2("cont e5", 27, -25);
    chk("cont e5 a1_valid", longint'(a1_valid), 0);
    cyc(1'b0, '0); chk("cont e6 a2_valid", longint'(a2_valid), 0);
    chk("cont hold a2", longint'($signed(a2)), 27);
    chk("cont hold d1", longint'($signed(d1)), -20);

    // Gapped input: 3 idle cycles after every sample
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, smp[i]);
      if (i % 2 == 1) chk_l1($sformatf("gap s%0d", i), (i == 1) ? 15 : 40, (i == 1) ? -10 : -20);
      else chk($sformatf("gap s%0d a1_valid", i), longint'(a1_valid), 0);
      cyc(1'b0, '0);
      chk($sformatf("gap g%0d a1_valid", i), longint'(a1_valid), 0);
      if (i == 3) chk_l2("gap l2", 27, -25);
      else chk($sformatf("gap g%0d a2_valid", i), longint'(a2_valid), 0);
      cyc(1'b0, '0);
      chk($sformatf("gap h%0d a2_valid", i), longint'(a2_valid), 0);
      cyc(1'b0, '0);
    end

    // Extremes and floor rounding
    cyc(1'b1, 32'h8000_0000); cyc(1'b1, 32'h7FFF_FFFF);
    chk_l1("extA", -1, -64'sd4294967295);
    cyc(1'b1, 32'h7FFF_FFFF); cyc(1'b1, 32'h7FFF_FFFF);
    chk_l1("extB", 64'sd2147483647, 0);
    cyc(1'b1, -32'sd3);
    chk_l2("extAB l2", 64'sd1073741823, -64'sd2147483648);
    cyc(1'b1, 32'd0);
    chk_l1("extC", -2, -3);

    // Reset mid-pair discards the half pair and restarts level 2
    cyc(1'b1, 32'd100); chk("mid s100 a1_valid", longint'(a1_valid), 0);
    rst = 1'b1;
    cyc(1'b1, 32'd55); chk_zero("mid rst");
    rst = 1'b0;
    cyc(1'b1, 32'd4); chk("mid s4 a1_valid", longint'(a1_valid), 0);
    cyc(1'b1, 32'd8); chk_l1("mid pair", 6, -4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0);
      chk($sformatf("mid idle%0d a2_valid", i), longint'(a2_valid), 0);
    end

    // Long ramp 0..63 from a clean state
    rst = 1'b1; cyc(1'b0, '0); rst = 1'b0;
    n_a1 = 0; n_a2 = 0;
    for (int i = 0; i < 66; i++) begin
      if (i < 64) cyc(1'b1, DW'(i));
      else cyc(1'b0, '0);
      if (a1_valid) begin
        chk($sformatf("ramp a1[%0d]", n_a1), longint'($signed(a1)), 2 * n_a1);
        chk($sformatf("ramp d1[%0d]", n_a1), longint'($signed(d1)), -1);
        n_a1++;
      end
      if (a2_valid) begin
        chk($sformatf("ramp a2[%0d]", n_a2), longint'($signed(a2)), 1 + 4 * n_a2);
        chk($sformatf("ramp d2[%0d]", n_a2), longint'($signed(d2)), -2);
        n_a2++;
      end
    end
    chk("ramp a1 count", n_a1, 32);
    chk("ramp a2 count", n_a2, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
